// File: rtl/pipe_control_n_if.sv
// Handshake bundle between the pipeline and its hazard controller.
// flush_req[k][j] is stage k's request to bubble boundary j (flat bit k*NUM_STAGES+j).
interface pipe_control_n_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
);
    logic [NUM_STAGES-1:0]                  stall_req;
    logic [NUM_STAGES-1:0][NUM_STAGES-1:0]  flush_req;
    logic                                   halt_req;
    logic                                   wdog_clr;
    logic [NUM_STAGES-1:0]                  stall;
    logic [NUM_STAGES-1:0]                  flush;
    logic                                   halt_ack;
    logic                                   wdog_err;
    logic [NUM_STAGES-1:0][CNT_W-1:0]       perf_stall_cnt;
    logic [NUM_STAGES-1:0][CNT_W-1:0]       perf_flush_cnt;

    modport master (
        output stall_req, flush_req, halt_req, wdog_clr,
        input  stall, flush, halt_ack, wdog_err, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  stall_req, flush_req, halt_req, wdog_clr,
        output stall, flush, halt_ack, wdog_err, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_control_n.sv
// N-stage hazard controller: stall/flush combine, debug-halt drain FSM, stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the per-boundary saturating stall/flush counters.
module pipe_control_n_bnd #(
    parameter int N = 4,
    parameter int J = 0
) (
    input  logic [N-1:0] stall_req,
    input  logic [N-1:0] flush_col,
    input  logic         hs,
    output logic         stall,
    output logic         flush
);
    // Only stages at or beyond this boundary may act on it.
    localparam logic [N-1:0] GE_MASK = {N{1'b1}} << J;

    logic rs, rf;
    assign rs    = |(stall_req & GE_MASK);
    assign rf    = |(flush_col & GE_MASK);
    assign flush = rf;
    assign stall = (rs | hs) & ~rf;
endmodule

module pipe_control_n #(
    parameter int NUM_STAGES = 4,
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input logic             clk,
    input logic             rst_n,
    pipe_control_n_if.slave bus
);
    localparam int DW = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                                 state, state_nxt;
    logic [DW-1:0]                          drain_cnt, drain_nxt;
    logic [WW-1:0]                          wd_cnt, wd_nxt;
    logic                                   halt_ack, wdog_err;
    logic [NUM_STAGES-1:0]                  hs, stall_v, flush_v;
    logic [NUM_STAGES-1:0][NUM_STAGES-1:0]  flush_col;
    logic                                   rs0, rs1;

    assign rs0 = |bus.stall_req;
    assign rs1 = |bus.stall_req[NUM_STAGES-1:1];

    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_bnd
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_col
            assign flush_col[j][k] = bus.flush_req[k][j];
        end
        pipe_control_n_bnd #(.N(NUM_STAGES), .J(j)) u_bnd (
            .stall_req (bus.stall_req),
            .flush_col (flush_col[j]),
            .hs        (hs[j]),
            .stall     (stall_v[j]),
            .flush     (flush_v[j])
        );
    end

    always_comb begin
        hs = '0;
        if (state == HALTED)     hs = '1;
        else if (state == DRAIN) hs[0] = 1'b1;
    end

    // Drain lasts NUM_STAGES-1 unstalled cycles: the counter reaching zero ends it.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            RUN: if (bus.halt_req) begin
                state_nxt = DRAIN;
                drain_nxt = DW'(NUM_STAGES - 1);
            end
            DRAIN: begin
                if (!bus.halt_req) begin
                    state_nxt = RUN;
                end else if (!rs1) begin
                    drain_nxt = drain_cnt - 1'b1;
                    if (drain_cnt <= DW'(1)) state_nxt = HALTED;
                end
            end
            HALTED: if (!bus.halt_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        wd_nxt = '0;
        if (state == RUN && rs0)
            wd_nxt = (wd_cnt == WW'(WDOG_LIMIT)) ? wd_cnt : wd_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            wd_cnt    <= '0;
            halt_ack  <= 1'b0;
            wdog_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            wd_cnt    <= wd_nxt;
            halt_ack  <= (state_nxt == HALTED);
            if (bus.wdog_clr)                    wdog_err <= 1'b0;
            else if (wd_nxt == WW'(WDOG_LIMIT))  wdog_err <= 1'b1;
        end
    end

    assign bus.stall    = stall_v;
    assign bus.flush    = flush_v;
    assign bus.halt_ack = halt_ack;
    assign bus.wdog_err = wdog_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [NUM_STAGES-1:0][CNT_W-1:0] pst_cnt, pfl_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst_cnt <= '0;
            pfl_cnt <= '0;
        end else begin
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (stall_v[j] && pst_cnt[j] != '1) pst_cnt[j] <= pst_cnt[j] + 1'b1;
                if (flush_v[j] && pfl_cnt[j] != '1) pfl_cnt[j] <= pfl_cnt[j] + 1'b1;
            end
        end
    end

    assign bus.perf_stall_cnt = pst_cnt;
    assign bus.perf_flush_cnt = pfl_cnt;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif
endmodule

// File: doc/pipe_control_n.md
Name: pipe_control_n

Overview:
Parametrised successor to the fixed 4-stage hazard controller. Combines per-stage stall/flush requests into per-boundary stall/flush controls for an N-stage in-order pipeline. Adds a debug-halt drain FSM, a stall watchdog, flush-over-stall priority and optional performance counters. Sits beside the pipeline registers; all pipeline registers and the PC take their controls from it.

Parameters:
NUM_STAGES, 4, number of requesting stages = number of controlled boundaries (boundary 0 = PC, boundary j = register after stage j-1); legal range 2..8
WDOG_LIMIT, 1024, consecutive request-stall cycles that raise wdog_err; legal range >=2
CNT_W, 32, perf counter width (used only with PIPE_CTRL_PERF_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_req  in  NUM_STAGES  bit k: stage k requests stall
flush_req  in  NUM_STAGES*NUM_STAGES  bit k*NUM_STAGES+j: stage k requests flush of boundary j; bits with j>k ignored
halt_req  in  1  level debug-halt request
wdog_clr  in  1  one-cycle pulse, clears wdog_err
stall  out  NUM_STAGES  bit j: hold boundary j
flush  out  NUM_STAGES  bit j: bubble boundary j
halt_ack  out  1  pipeline drained and frozen
wdog_err  out  1  sticky watchdog error
perf_stall_cnt  out  NUM_STAGES*CNT_W  per-boundary stall-cycle counters
perf_flush_cnt  out  NUM_STAGES*CNT_W  per-boundary flush-cycle counters

Behaviour:
- Request combine (combinational, zero latency): rs[j] = OR of stall_req[k] for k>=j; rf[j] = OR of flush_req[k*N+j] for k>=j.
- Priority: flush[j] = rf[j]; stall[j] = (rs[j] | hs[j]) & ~rf[j]. A flushed boundary never stalls in the same cycle.
- Halt FSM, states RUN, DRAIN, HALTED; reset state RUN.
  - RUN: hs = 0. halt_req=1 -> DRAIN, load drain_cnt = NUM_STAGES-1.
  - DRAIN: hs[0]=1 (PC frozen, older stages drain). drain_cnt decrements on cycles with rs[1..N-1] all 0; holds otherwise. drain_cnt==0 on such a cycle -> HALTED. halt_req=0 -> RUN immediately (abort, no ack).
  - HALTED: hs = all ones; halt_ack=1 (registered, asserted first cycle in HALTED). halt_req=0 -> RUN, halt_ack=0 the following cycle.
  - Flushes pass through in every state; a flush does not reset drain_cnt.
- Watchdog: wd_cnt increments each cycle rs[0]=1 in RUN, saturates at WDOG_LIMIT; clears to 0 on any cycle rs[0]=0 or state != RUN. wd_cnt reaching WDOG_LIMIT sets wdog_err next edge; stays set until wdog_clr (clear wins over set in the same cycle) or reset. Halt-induced stalls never count.
- Reset (async assert, sync release by system): state RUN, drain_cnt 0, wd_cnt 0, halt_ack 0, wdog_err 0, perf counters 0. stall/flush remain combinational from inputs (hs=0) during reset.
- Width rules: drain_cnt $clog2(NUM_STAGES) bits minimum 1; wd_cnt $clog2(WDOG_LIMIT+1) bits.

Optional Feature:
PIPE_CTRL_PERF_EN. Defined: per boundary j, perf_stall_cnt[j] increments on cycles stall[j]=1; perf_flush_cnt[j] increments on cycles flush[j]=1; saturating at 2^CNT_W-1; reset to 0. Not defined: counters not instantiated, both perf ports tied to 0, ports still present.

Test Plan:
- N=4, stall_req=4'b0100 -> stall=4'b0111, flush=0; then flush_req bit 2*4+1 and bit 2*4+0 also set -> flush=4'b0011, stall=4'b0100.
- flush_req bit 1*4+3 (j>k) set alone -> flush=0, stall=0 (ignored).
- halt_req=1, no stall_req -> stall=4'b0001 for 3 cycles, then HALTED: stall=4'b1111, halt_ack=1; halt_req=0 -> halt_ack=0 next cycle, stall=0.
- DRAIN with stall_req=4'b0100 held 5 cycles -> drain_cnt frozen, halt_ack delayed 5 cycles; halt_req dropped mid-DRAIN -> RUN, halt_ack never asserts.
- WDOG_LIMIT=8, stall_req[0]=1 held 8 cycles -> wdog_err=1 after 8th cycle edge; stall released and wdog_clr pulsed -> wdog_err=0; wdog_clr same cycle as set -> stays 0; async rst_n low mid-run -> all registers 0 immediately.
- With PIPE_CTRL_PERF_EN, CNT_W=4: stall boundary 0 for 20 cycles -> perf_stall_cnt[0]=15 (saturated); without macro -> all perf ports 0.
